// File: rtl/control_barrera_pkg.sv
// Shared types and constants for the parking-gate barrier controller.
package control_barrera_pkg;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    ABRIENDO = 2'd1,
    ABIERTA  = 2'd2,
    CERRANDO = 2'd3
  } estado_t;

  localparam logic DIR_ENTRADA = 1'b0;
  localparam logic DIR_SALIDA  = 1'b1;

  localparam int unsigned ESPACIO_W = 4;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/control_barrera_arbitro_rr.sv
// Two-requester round-robin arbiter; on a tie the side opposite the last winner wins.
module arbitro_rr
  import control_barrera_pkg::*;
(
  input  logic ent_ok,
  input  logic sal_ok,
  input  logic ultimo,
  input  logic habilitar,
  output logic conceder,
  output logic ganador
);

  always_comb begin
    conceder = habilitar && (ent_ok || sal_ok);
    ganador  = DIR_ENTRADA;
    if (ent_ok && sal_ok) begin
      ganador = ~ultimo;
    end else if (sal_ok) begin
      ganador = DIR_SALIDA;
    end
  end

endmodule

// File: rtl/control_barrera.sv
// Barrier sequencer for a one-lane parking gate: arbitrates entry/exit, drives the
// motor through open/wait/close and emits one count pulse per completed passage.
module control_barrera
  import control_barrera_pkg::*;
#(
  parameter int unsigned CAPACIDAD = 7,
  parameter int unsigned T_MOVER   = 4,
  parameter int unsigned T_ESPERA  = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sensor_entrada,
  input  logic                 sensor_salida,
  input  logic                 paso,
  input  logic [ESPACIO_W-1:0] espacio,
  output logic                 motor_abrir,
  output logic                 motor_cerrar,
  output logic                 entrada,
  output logic                 salida,
  output logic                 lleno,
  output logic                 sentido
);

  localparam int unsigned TIMER_W = $clog2(max2(T_MOVER, T_ESPERA) + 1);

  localparam logic [ESPACIO_W-1:0] CAP_E      = ESPACIO_W'(CAPACIDAD);
  localparam logic [TIMER_W-1:0]   FIN_MOVER  = TIMER_W'(T_MOVER - 1);
  localparam logic [TIMER_W-1:0]   FIN_ESPERA = TIMER_W'(T_ESPERA - 1);
  localparam logic [TIMER_W-1:0]   TIMER_MAX  = '1;

  estado_t            estado_q, estado_d;
  logic [TIMER_W-1:0] timer_q, timer_d, timer_inc;
  logic               contado_q, contado_d;
  logic               ultimo_q, ultimo_d;
  logic               sentido_d;
  logic               paso_q;
  logic               entrada_d, salida_d;
  logic               ent_ok, sal_ok, conceder, ganador;

  // Eligibility only matters while idle; the arbiter is gated to REPOSO.
  assign ent_ok = sensor_entrada && (espacio < CAP_E);
  assign sal_ok = sensor_salida && (espacio != '0);

  arbitro_rr u_arbitro (
    .ent_ok    (ent_ok),
    .sal_ok    (sal_ok),
    .ultimo    (ultimo_q),
    .habilitar (estado_q == REPOSO),
    .conceder  (conceder),
    .ganador   (ganador)
  );

  assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    estado_d  = estado_q;
    timer_d   = timer_q;
    contado_d = contado_q;
    ultimo_d  = ultimo_q;
    sentido_d = sentido;
    entrada_d = 1'b0;
    salida_d  = 1'b0;

    unique case (estado_q)
      REPOSO: begin
        if (conceder) begin
          estado_d  = ABRIENDO;
          timer_d   = '0;
          sentido_d = ganador;
          ultimo_d  = ganador;
        end
      end

      ABRIENDO: begin
        if (timer_q >= FIN_MOVER) begin
          estado_d = ABIERTA;
          timer_d  = '0;
        end else begin
          timer_d = timer_inc;
        end
      end

      ABIERTA: begin
        if (paso && !paso_q && !contado_q) begin
          entrada_d = (sentido == DIR_ENTRADA);
          salida_d  = (sentido == DIR_SALIDA);
          contado_d = 1'b1;
        end else if (contado_q && !paso) begin
          estado_d = CERRANDO;
          timer_d  = '0;
        end else if (!contado_q && !paso && (timer_q >= FIN_ESPERA)) begin
          estado_d = CERRANDO;
          timer_d  = '0;
        end else if (!paso) begin
          timer_d = timer_inc;
        end
      end

      CERRANDO: begin
        // An obstruction reopens for the same grant; contado survives so no recount.
        if (paso) begin
          estado_d = ABRIENDO;
          timer_d  = '0;
        end else if (timer_q >= FIN_MOVER) begin
          estado_d  = REPOSO;
          timer_d   = '0;
          contado_d = 1'b0;
        end else begin
          timer_d = timer_inc;
        end
      end

      default: begin
        estado_d = REPOSO;
        timer_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q     <= REPOSO;
      timer_q      <= '0;
      contado_q    <= 1'b0;
      ultimo_q     <= DIR_SALIDA;
      paso_q       <= 1'b0;
      sentido      <= 1'b0;
      entrada      <= 1'b0;
      salida       <= 1'b0;
      motor_abrir  <= 1'b0;
      motor_cerrar <= 1'b0;
      lleno        <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      timer_q      <= timer_d;
      contado_q    <= contado_d;
      ultimo_q     <= ultimo_d;
      paso_q       <= paso;
      sentido      <= sentido_d;
      entrada      <= entrada_d;
      salida       <= salida_d;
      motor_abrir  <= (estado_d == ABRIENDO);
      motor_cerrar <= (estado_d == CERRANDO);
      lleno        <= (espacio >= CAP_E);
    end
  end

endmodule

// File: tb/tb_control_barrera.sv
// Directed bench for control_barrera: vector table plus hand-written multi-cycle sequences.
module tb_control_barrera;

  logic       clk, rst_n;
  logic       sensor_entrada, sensor_salida, paso;
  logic [3:0] espacio;
  logic       motor_abrir, motor_cerrar, entrada, salida, lleno, sentido;

  int total = 0;
  int bad   = 0;
  int n_ent = 0;
  int n_sal = 0;

  control_barrera dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sensor_entrada (sensor_entrada),
    .sensor_salida  (sensor_salida),
    .paso           (paso),
    .espacio        (espacio),
    .motor_abrir    (motor_abrir),
    .motor_cerrar   (motor_cerrar),
    .entrada        (entrada),
    .salida         (salida),
    .lleno          (lleno),
    .sentido        (sentido)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       se, ss, pa;
    logic [3:0] esp;
    logic       ab, ce, en, sa, ll, sn;
  } vec_t;

  vec_t tabla[$];

  function automatic vec_t mk(input logic se, input logic ss, input logic pa,
                              input logic [3:0] esp, input logic ab, input logic ce,
                              input logic en, input logic sa, input logic ll,
                              input logic sn);
    vec_t v;
    v.se = se; v.ss = ss; v.pa = pa; v.esp = esp;
    v.ab = ab; v.ce = ce; v.en = en; v.sa = sa; v.ll = ll; v.sn = sn;
    return v;
  endfunction

  task automatic chk(input string n, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (entrada) n_ent++;
    if (salida)  n_sal++;
    chk("pulses_exclusive", int'(entrada && salida), 0);
    chk("motor_exclusive", int'(motor_abrir && motor_cerrar), 0);
  endtask

  task automatic esperar(input bit cual, input logic val, input string n);
    logic cur;
    bit   ok;
    ok  = 1'b0;
    cur = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cur = cual ? motor_cerrar : motor_abrir;
      if (cur == val) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: timeout, got %0d expected %0d", n, cur, val);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".motor_abrir"},  int'(motor_abrir),  0);
    chk({tag, ".motor_cerrar"}, int'(motor_cerrar), 0);
    chk({tag, ".entrada"},      int'(entrada),      0);
    chk({tag, ".salida"},       int'(salida),       0);
    chk({tag, ".lleno"},        int'(lleno),        0);
    chk({tag, ".sentido"},      int'(sentido),      0);
  endtask

  // One full barrier cycle with a 3-cycle car passage; sensors are left as the caller set them.
  task automatic ciclo(input logic exp_s, input string tag);
    int e0, s0;
    e0 = n_ent;
    s0 = n_sal;
    esperar(1'b0, 1'b1, {tag, ".opens"});
    chk({tag, ".sentido"}, int'(sentido), int'(exp_s));
    esperar(1'b0, 1'b0, {tag, ".open_done"});
    paso = 1'b1;
    repeat (3) tick();
    paso = 1'b0;
    esperar(1'b1, 1'b1, {tag, ".closes"});
    esperar(1'b1, 1'b0, {tag, ".close_done"});
    chk({tag, ".n_entrada"}, n_ent - e0, (exp_s == 1'b0) ? 1 : 0);
    chk({tag, ".n_salida"},  n_sal - s0, (exp_s == 1'b1) ? 1 : 0);
  endtask

  initial begin
    int e0, s0, n, m;

    // Single entry, espacio=3.
    tabla.push_back(mk(1,0,0,4'd3, 1,0,0,0,0,0));
    tabla.push_back(mk(0,0,0,4'd3, 1,0,0,0,0,0));
    tabla.push_back(mk(0,0,0,4'd3, 1,0,0,0,0,0));
    tabla.push_back(mk(0,0,0,4'd3, 1,0,0,0,0,0));
    tabla.push_back(mk(0,0,0,4'd3, 0,0,0,0,0,0));
    tabla.push_back(mk(0,0,1,4'd3, 0,0,1,0,0,0));
    tabla.push_back(mk(0,0,1,4'd3, 0,0,0,0,0,0));
    tabla.push_back(mk(0,0,1,4'd3, 0,0,0,0,0,0));
    tabla.push_back(mk(0,0,0,4'd3, 0,1,0,0,0,0));
    tabla.push_back(mk(0,0,0,4'd3, 0,1,0,0,0,0));
    tabla.push_back(mk(0,0,0,4'd3, 0,1,0,0,0,0));
    tabla.push_back(mk(0,0,0,4'd3, 0,1,0,0,0,0));
    tabla.push_back(mk(0,0,0,4'd3, 0,0,0,0,0,0));
    tabla.push_back(mk(0,0,0,4'd3, 0,0,0,0,0,0));
    // Full lot: entry refused, then exit granted.
    tabla.push_back(mk(1,0,0,4'd7, 0,0,0,0,1,0));
    tabla.push_back(mk(1,0,0,4'd7, 0,0,0,0,1,0));
    tabla.push_back(mk(1,0,0,4'd7, 0,0,0,0,1,0));
    tabla.push_back(mk(1,1,0,4'd7, 1,0,0,0,1,1));
    tabla.push_back(mk(0,0,0,4'd7, 1,0,0,0,1,1));
    tabla.push_back(mk(0,0,0,4'd7, 1,0,0,0,1,1));
    tabla.push_back(mk(0,0,0,4'd7, 1,0,0,0,1,1));
    tabla.push_back(mk(0,0,0,4'd7, 0,0,0,0,1,1));
    tabla.push_back(mk(0,0,1,4'd7, 0,0,0,1,1,1));
    tabla.push_back(mk(0,0,0,4'd7, 0,1,0,0,1,1));
    tabla.push_back(mk(0,0,0,4'd7, 0,1,0,0,1,1));
    tabla.push_back(mk(0,0,0,4'd7, 0,1,0,0,1,1));
    tabla.push_back(mk(0,0,0,4'd7, 0,1,0,0,1,1));
    tabla.push_back(mk(0,0,0,4'd7, 0,0,0,0,1,1));

    rst_n = 1'b0;
    sensor_entrada = 1'b0;
    sensor_salida  = 1'b0;
    paso           = 1'b0;
    espacio        = 4'd0;
    #12;
    chk_all_zero("reset");
    rst_n = 1'b1;

    foreach (tabla[i]) begin
      sensor_entrada = tabla[i].se;
      sensor_salida  = tabla[i].ss;
      paso           = tabla[i].pa;
      espacio        = tabla[i].esp;
      tick();
      chk($sformatf("v%0d.motor_abrir", i),  int'(motor_abrir),  int'(tabla[i].ab));
      chk($sformatf("v%0d.motor_cerrar", i), int'(motor_cerrar), int'(tabla[i].ce));
      chk($sformatf("v%0d.entrada", i),      int'(entrada),      int'(tabla[i].en));
      chk($sformatf("v%0d.salida", i),       int'(salida),       int'(tabla[i].sa));
      chk($sformatf("v%0d.lleno", i),        int'(lleno),        int'(tabla[i].ll));
      chk($sformatf("v%0d.sentido", i),      int'(sentido),      int'(tabla[i].sn));
    end

    // Simultaneous requests alternate; last grant was exit, so entry goes first.
    espacio        = 4'd3;
    sensor_entrada = 1'b1;
    sensor_salida  = 1'b1;
    ciclo(1'b0, "rr1");
    ciclo(1'b1, "rr2");
    ciclo(1'b0, "rr3");
    sensor_entrada = 1'b0;
    sensor_salida  = 1'b0;
    tick();

    // Timeout: entry granted, no car ever passes.
    e0 = n_ent; s0 = n_sal;
    sensor_entrada = 1'b1;
    tick();
    chk("to.opens", int'(motor_abrir), 1);
    sensor_entrada = 1'b0;
    esperar(1'b0, 1'b0, "to.open_done");
    n = 0;
    do begin
      tick();
      n++;
    end while (!motor_cerrar && n < 40);
    chk("to.wait_cycles", n, 20);
    m = 0;
    while (motor_cerrar && m < 20) begin
      tick();
      m++;
    end
    chk("to.close_cycles", m, 4);
    chk("to.n_entrada", n_ent - e0, 0);
    chk("to.n_salida",  n_sal - s0, 0);

    // Obstruction during the second closing cycle.
    e0 = n_ent; s0 = n_sal;
    sensor_entrada = 1'b1;
    tick();
    sensor_entrada = 1'b0;
    esperar(1'b0, 1'b0, "ob.open_done");
    paso = 1'b1;
    tick();
    tick();
    paso = 1'b0;
    esperar(1'b1, 1'b1, "ob.closes");
    tick();
    paso = 1'b1;
    tick();
    chk("ob.reopen_abrir",  int'(motor_abrir),  1);
    chk("ob.reopen_cerrar", int'(motor_cerrar), 0);
    chk("ob.sentido",       int'(sentido),      0);
    tick();
    paso = 1'b0;
    esperar(1'b0, 1'b0, "ob.reopen_done");
    esperar(1'b1, 1'b1, "ob.closes2");
    esperar(1'b1, 1'b0, "ob.close_done");
    chk("ob.n_entrada", n_ent - e0, 1);
    chk("ob.n_salida",  n_sal - s0, 0);

    // Asynchronous reset in ABRIENDO, then a tie must go to entry again.
    sensor_entrada = 1'b1;
    tick();
    tick();
    chk("ar.before", int'(motor_abrir), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("ar");
    sensor_entrada = 1'b0;
    tick();
    rst_n = 1'b1;
    sensor_entrada = 1'b1;
    sensor_salida  = 1'b1;
    tick();
    chk("ar.tie_abrir",   int'(motor_abrir), 1);
    chk("ar.tie_sentido", int'(sentido),     0);
    sensor_entrada = 1'b0;
    sensor_salida  = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_barrera.md
Name: control_barrera

Overview:
- Sequences the single shared barrier of a one-lane parking gate and arbitrates between the entry-side and exit-side requesters.
- Drives the barrier motor through open / wait / close phases.
- Issues exactly one 1-cycle count pulse per completed car passage to the car counter, whose `entrada`/`salida` inputs it feeds.
- Reads back the counter's `espacio` value to refuse entry when the lot is full and exit when it is empty.

Parameters:
- CAPACIDAD, 7, maximum number of cars; entry is refused when espacio >= CAPACIDAD.
- T_MOVER, 4, clock cycles the barrier motor runs to fully open or fully close.
- T_ESPERA, 20, maximum cycles the barrier stays open waiting for a car before closing without counting.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- sensor_entrada  in  1  level, car waiting at the entry side (pre-synchronised).
- sensor_salida  in  1  level, car waiting at the exit side (pre-synchronised).
- paso  in  1  level, car present under the barrier (pre-synchronised).
- espacio  in  4  current occupancy from the car counter.
- motor_abrir  out  1  barrier motor opening drive.
- motor_cerrar  out  1  barrier motor closing drive.
- entrada  out  1  1-cycle pulse to the counter: one car entered.
- salida  out  1  1-cycle pulse to the counter: one car left.
- lleno  out  1  registered, espacio >= CAPACIDAD.
- sentido  out  1  direction of the current/last grant: 0 = entry, 1 = exit.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; state REPOSO; timer 0; paso_q 0; contado 0.
  - ultimo=1, so the first tie is granted to entry.
  - Reset mid-operation abandons the cycle with no pulse; the motor stops immediately.
- Eligibility, evaluated in REPOSO only:
  - ent_ok = sensor_entrada && espacio < CAPACIDAD.
  - sal_ok = sensor_salida && espacio > 0.
- Arbitration:
  - Only one eligible requester: it wins.
  - Both eligible: the side opposite ultimo wins (round-robin).
  - On grant: sentido <= winner, ultimo <= winner.
- FSM states: REPOSO, ABRIENDO, ABIERTA, CERRANDO.
- REPOSO:
  - Motor outputs 0.
  - On a grant: -> ABRIENDO, timer <= 0.
  - No grant: stay.
- ABRIENDO:
  - motor_abrir=1.
  - Timer counts each cycle; after T_MOVER cycles in state -> ABIERTA, timer <= 0.
- ABIERTA:
  - Motor outputs 0.
  - paso rising edge (paso && !paso_q) with contado=0: pulse entrada (sentido=0) or salida (sentido=1) for exactly 1 cycle, registered, asserted the cycle after the edge; contado <= 1.
  - Leave -> CERRANDO (timer <= 0) when contado=1 and paso=0.
  - Leave -> CERRANDO when contado=0 and the timer reaches T_ESPERA (no pulse).
  - The timer is frozen while paso=1.
- CERRANDO:
  - motor_cerrar=1.
  - If paso=1 (obstruction): -> ABRIENDO with the same sentido; timer <= 0; contado kept, so no second count.
  - After T_MOVER cycles: -> REPOSO, contado <= 0.
- Pulses:
  - entrada and salida are never high together.
  - At most one pulse per grant.
- lleno: registered every cycle, independent of state.
- Requests are ignored outside REPOSO. A requester dropping its sensor after the grant does not abort the cycle; it times out instead.
- Timer width: $clog2(max(T_MOVER, T_ESPERA)+1) bits, saturating; never wraps.
- motor_abrir and motor_cerrar are mutually exclusive in all states.

Decomposition:
- Shared package control_barrera_pkg:
  - State enum (REPOSO, ABRIENDO, ABIERTA, CERRANDO).
  - Direction constants DIR_ENTRADA=0, DIR_SALIDA=1.
- One natural sub-module: arbitro_rr, the 2-requester round-robin arbiter.
  - Inputs: ent_ok, sal_ok, ultimo, habilitar.
  - Outputs: conceder, ganador.
- Timer and FSM stay in the top module.

Test Plan:
- Single entry, espacio=3, sensor_entrada=1 -> motor_abrir high 4 cycles; ABIERTA; paso pulse of 3 cycles -> entrada pulses once the cycle after the paso edge; motor_cerrar high 4 cycles; back to REPOSO; salida never asserted.
- Full lot, espacio=7, sensor_entrada=1 -> lleno=1, barrier never opens. Then add sensor_salida=1 -> exit granted, sentido=1, one salida pulse.
- Simultaneous requests, espacio=3, both sensors held high -> grants alternate entry, exit, entry across three cycles; pulses match sentido.
- Timeout: grant entry, never assert paso -> closes 20 cycles after reaching ABIERTA; no pulse; REPOSO after 4 more cycles.
- Obstruction: assert paso during CERRANDO cycle 2 -> returns to ABRIENDO, reopens; after paso falls it closes; total entrada pulses = 1.
- Async reset: assert rst_n=0 in ABRIENDO -> all outputs 0 immediately, without waiting for a clock edge. After release, a tie of both requests -> entry wins first.
